// File: rtl/memristor_array_sequencer_if.sv
// Command/response bus of the memristor sequencer: the command source is master,
// the sequencer is slave.
interface memristor_array_sequencer_if #(
  parameter int CH_W  = 2,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CH_W-1:0]  cmd_ch;
  logic [LEN_W-1:0] cmd_len;
  logic             rsp_valid;
  logic             rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_len,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_len,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/memristor_array_sequencer.sv
// Command-driven READ/SET/RESET pulse sequencer for NUM_CH memristor cells.
// Optional program-verify loop with retries: define MEMSEQ_VERIFY_EN.
module memristor_array_sequencer #(
  parameter int NUM_CH    = 3,
  parameter int CH_W      = 2,
  parameter int LEN_W     = 8,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int MAX_RETRY = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  memristor_array_sequencer_if.slave cmd,
  input  logic [NUM_CH-1:0]    sense_i,
  output logic [NUM_CH-1:0]    sel_o,
  output logic [NUM_CH-1:0]    io_oeb_o,
  output logic                 drv_en_o,
  output logic                 drv_pol_o,
  output logic                 read_o,
  output logic                 busy_o
);

  if ((2**CH_W) < NUM_CH || SETUP_CYC < 1 || HOLD_CYC < 1 || MAX_RETRY < 0) begin : g_param_chk
    $error("memristor_array_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [CH_W-1:0]  ch;
    logic [LEN_W-1:0] len;
  } cmd_t;

  localparam logic [1:0]       OP_READ    = 2'b00;
  localparam logic [1:0]       OP_SET     = 2'b01;
  localparam logic [1:0]       OP_ILL     = 2'b11;
  localparam logic [LEN_W-1:0] SETUP_LAST = LEN_W'(SETUP_CYC - 1);
  localparam logic [LEN_W-1:0] HOLD_LAST  = LEN_W'(HOLD_CYC - 1);
  localparam logic [CH_W:0]    NUM_CH_L   = (CH_W+1)'(NUM_CH);

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] pulse_last;
  logic             sense_q, sense_d;
  logic             err_q, err_d;
  logic             accept, illegal;
  logic             rd_phase_q, rd_phase_d, data_src_d;

  logic [NUM_CH-1:0] onehot_d;
  logic [NUM_CH-1:0] sel_d, sel_q, oeb_q;
  logic drv_en_d, drv_en_q, drv_pol_d, drv_pol_q, read_d, read_q;
  logic ready_d, ready_q, busy_q;
  logic rsp_valid_d, rsp_valid_q, rsp_data_d, rsp_data_q, rsp_err_d, rsp_err_q;

`ifdef MEMSEQ_VERIFY_EN
  localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;
  logic             vfy_q, vfy_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  assign rd_phase_q = (cmd_q.op == OP_READ) | vfy_q;
  assign rd_phase_d = (cmd_d.op == OP_READ) | vfy_d;
  assign data_src_d = 1'b1;
`else
  assign rd_phase_q = (cmd_q.op == OP_READ);
  assign rd_phase_d = (cmd_d.op == OP_READ);
  assign data_src_d = (cmd_d.op == OP_READ);
`endif

  assign accept     = cmd.cmd_valid & ready_q;
  assign illegal    = (cmd.cmd_op == OP_ILL) || ({1'b0, cmd.cmd_ch} >= NUM_CH_L);
  assign pulse_last = (cmd_q.len == '0) ? '0 : cmd_q.len - 1'b1;

  // Next state, including the latched command and phase bookkeeping.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q + 1'b1;
    sense_d = sense_q;
    err_d   = err_q;
`ifdef MEMSEQ_VERIFY_EN
    vfy_d   = vfy_q;
    rty_d   = rty_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          cmd_d   = '{op: cmd.cmd_op, ch: cmd.cmd_ch, len: cmd.cmd_len};
          sense_d = 1'b0;
          err_d   = illegal;
          state_d = illegal ? DONE : SETUP;
`ifdef MEMSEQ_VERIFY_EN
          vfy_d   = 1'b0;
          rty_d   = '0;
`endif
        end
      end
      SETUP: if (cnt_q == SETUP_LAST) begin
        state_d = PULSE;
        cnt_d   = '0;
      end
      PULSE: if (cnt_q == pulse_last) begin
        state_d = HOLD;
        cnt_d   = '0;
        if (rd_phase_q) sense_d = sense_i[cmd_q.ch];
      end
      HOLD: if (cnt_q == HOLD_LAST) begin
        state_d = DONE;
        cnt_d   = '0;
`ifdef MEMSEQ_VERIFY_EN
        // Program phase chains into a read-back; a wrong read-back reprograms.
        if (cmd_q.op != OP_READ) begin
          if (!vfy_q) begin
            vfy_d   = 1'b1;
            state_d = SETUP;
          end else if (sense_q != (cmd_q.op == OP_SET)) begin
            if (rty_q == RTY_W'(MAX_RETRY)) begin
              err_d = 1'b1;
            end else begin
              rty_d   = rty_q + 1'b1;
              vfy_d   = 1'b0;
              state_d = SETUP;
            end
          end
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign onehot_d[g] = (cmd_d.ch == CH_W'(g));
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    sel_d       = '0;
    drv_en_d    = 1'b0;
    drv_pol_d   = 1'b0;
    read_d      = 1'b0;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_d)
      IDLE:        ready_d = 1'b1;
      SETUP, HOLD: sel_d   = onehot_d;
      PULSE: begin
        sel_d = onehot_d;
        if (rd_phase_d) begin
          read_d = 1'b1;
        end else begin
          drv_en_d  = 1'b1;
          drv_pol_d = (cmd_d.op == OP_SET);
        end
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_d;
        rsp_data_d  = data_src_d & sense_d;
      end
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      sense_q     <= 1'b0;
      err_q       <= 1'b0;
      sel_q       <= '0;
      oeb_q       <= '1;
      drv_en_q    <= 1'b0;
      drv_pol_q   <= 1'b0;
      read_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef MEMSEQ_VERIFY_EN
      vfy_q       <= 1'b0;
      rty_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      sense_q     <= sense_d;
      err_q       <= err_d;
      sel_q       <= sel_d;
      oeb_q       <= ~sel_d;
      drv_en_q    <= drv_en_d;
      drv_pol_q   <= drv_pol_d;
      read_q      <= read_d;
      ready_q     <= ready_d;
      busy_q      <= ~ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef MEMSEQ_VERIFY_EN
      vfy_q       <= vfy_d;
      rty_q       <= rty_d;
`endif
    end
  end

  assign sel_o         = sel_q;
  assign io_oeb_o      = oeb_q;
  assign drv_en_o      = drv_en_q;
  assign drv_pol_o     = drv_pol_q;
  assign read_o        = read_q;
  assign busy_o        = busy_q;
  assign cmd.cmd_ready = ready_q;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_data  = rsp_data_q;
  assign cmd.rsp_err   = rsp_err_q;

endmodule
